pipeline_hazard_sequencer: RTL
==============================

PIPELINE_HAZARD_SEQUENCER -- requirements
Module: pipeline_hazard_sequencer

Parameters
REQ-001 SHALL have TIMEOUT_CYCLES, default 256: number of consecutive memory-wait cycles before the timeout fault.
REQ-002 SHALL have CNT_W, default 16: width of each performance counter.

Interface
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 PCSrcE  input  2  Execute next-PC select; 2'b01 means branch taken, 2'b10 means jump taken, other values mean no redirect.
REQ-006 ResultSrcE0  input  1  Execute instruction is a load.
REQ-007 RdE  input  5  Execute destination register.
REQ-008 Rs1D, Rs2D  input  5 each  Decode source registers.
REQ-009 MemReqM  input  1  Memory stage has an active load or store.
REQ-010 MemReadyM  input  1  data memory has completed the access this cycle.
REQ-011 StallF, StallD, StallE, StallM  output  1 each  hold the corresponding pipeline register.
REQ-012 FlushD, FlushE, FlushW  output  1 each  load a bubble into the corresponding pipeline register.
REQ-013 MemTimeout  output  1  sticky fault flag.
REQ-014 StallCnt, FlushCnt  output  CNT_W each  saturating performance counters.

Function
REQ-015 SHALL implement FSM states RUN, MEM_WAIT and FAULT; the reset state is RUN.
REQ-016 Outputs SHALL be combinational from the current state and the inputs; the counters and MemTimeout SHALL be registered.
REQ-017 memstall = MemReqM & ~MemReadyM & (state != FAULT).
REQ-018 loaduse = ResultSrcE0 & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
REQ-019 taken = (PCSrcE == 2'b01) | (PCSrcE == 2'b10).
REQ-020 Priority SHALL be, highest first: FAULT, memstall, taken, loaduse.
REQ-021 If memstall: StallF, StallD, StallE and StallM = 1, FlushW = 1, FlushD and FlushE = 0; any branch flush is deferred because E is frozen and PCSrcE re-evaluates on release.
REQ-022 Else if taken: FlushD = 1 and FlushE = 1, all stalls = 0; a taken branch overrides a concurrent loaduse.
REQ-023 Else if loaduse: StallF = 1, StallD = 1, FlushE = 1, all other outputs 0, for exactly one cycle per hazard.
REQ-024 Otherwise all stall and flush outputs SHALL be 0.
REQ-025 Transition RUN->MEM_WAIT SHALL occur when memstall is 1 at the clock edge; the wait counter is cleared to 0.
REQ-026 In MEM_WAIT the wait counter SHALL increment each cycle with memstall = 1.
REQ-027 Transition MEM_WAIT->RUN SHALL occur on the edge where MemReadyM = 1; stalls SHALL drop in that same cycle (zero extra latency).
REQ-028 Transition MEM_WAIT->FAULT SHALL occur when the wait counter reaches TIMEOUT_CYCLES-1 with memstall still 1.
REQ-029 FAULT SHALL set MemTimeout = 1 and hold StallF, StallD, StallE and StallM = 1 with FlushW = 1.
REQ-030 FAULT SHALL be exited only by reset.
REQ-031 MemReqM deasserting while in MEM_WAIT SHALL be treated as ready and return the FSM to RUN.
REQ-032 StallCnt SHALL increment on every cycle with StallF = 1.
REQ-033 FlushCnt SHALL increment on every cycle with FlushE = 1 caused by taken (not by loaduse).
REQ-034 Both counters SHALL saturate at all-ones and never wrap.
REQ-035 A back-to-back memstall on the cycle after release SHALL re-enter MEM_WAIT with the wait counter cleared.

Reset
REQ-036 rst_n low SHALL asynchronously set state = RUN, wait counter = 0, StallCnt = 0, FlushCnt = 0 and MemTimeout = 0.
REQ-037 While rst_n is low, all stall and flush outputs SHALL be forced to 0 regardless of inputs.
REQ-038 Reset asserted mid-MEM_WAIT or in FAULT SHALL abandon the wait with no pending flush retained.
REQ-039 Release of rst_n SHALL be synchronised by the integrator; the block adds no reset synchroniser.

Verification
REQ-040 Load-use: ResultSrcE0=1, RdE=5, Rs1D=5, PCSrcE=0 for 1 cycle -> StallF=StallD=FlushE=1 for that cycle; StallCnt=1, FlushCnt=0.
REQ-041 Taken branch plus load-use: PCSrcE=2'b01, ResultSrcE0=1, RdE=Rs2D=7 -> FlushD=FlushE=1 and StallF=0; FlushCnt increments by 1.
REQ-042 Memory wait: MemReqM=1 with MemReadyM=0 for 3 cycles, then 1 -> all stalls=1 and FlushW=1 for 3 cycles, all 0 on the ready cycle; StallCnt=3; state returns to RUN.
REQ-043 Branch during wait: PCSrcE=2'b10 throughout a 2-cycle memstall -> FlushD/FlushE=0 during the wait, then 1 on the release cycle.
REQ-044 Timeout: TIMEOUT_CYCLES=4, MemReadyM held 0 -> MemTimeout=1 after the 4th wait cycle; stalls remain 1 even after MemReadyM=1; rst_n pulse clears all state and outputs.
REQ-045 Saturation: CNT_W=4 with 20 load-use cycles -> StallCnt=15 and does not wrap.

Source files
------------

// File: rtl/pipeline_hazard_sequencer.sv
// Hazard sequencer for a 5-stage pipeline: resolves memory waits, taken
// branches/jumps and load-use hazards into stall/flush controls plus perf counters.
module pipeline_hazard_sequencer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       PCSrcE,
  input  logic             ResultSrcE0,
  input  logic [4:0]       RdE,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t            state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              mem_timeout_reg;

  logic in_fault;
  logic memstall;
  logic loaduse;
  logic taken;
  logic flush_by_taken;

  always_comb begin
    in_fault = (state_reg == FAULT);
    memstall = MemReqM & ~MemReadyM & ~in_fault;
    loaduse  = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
    taken    = (PCSrcE == 2'b01) | (PCSrcE == 2'b10);
  end

  // A frozen Execute stage masks any redirect; PCSrcE is re-evaluated on release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst_n) begin
      if (in_fault || memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (taken) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (loaduse) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign flush_by_taken = rst_n & ~in_fault & ~memstall & taken;
  assign MemTimeout     = mem_timeout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (memstall) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= '0;
          end
        end
        MEM_WAIT: begin
          // Ready or a withdrawn request both release the pipeline.
          if (!memstall) begin
            state_reg <= RUN;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_reg       <= FAULT;
            mem_timeout_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        FAULT: begin
          mem_timeout_reg <= 1'b1;
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc = {flush_by_taken, StallF};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign StallCnt = cnt_val[0];
  assign FlushCnt = cnt_val[1];

endmodule
